// File: rtl/gate_sched.sv
// gate_sched: sequences measurement gates for the measure datapath.
// Single-shot or continuous gating, per-gate timeout, host stop, and an
// optional automatic range step selected with GATE_SCHED_AUTO_RANGE_EN.
module gate_sched #(
  parameter int unsigned HOLDOFF_CYC = 16,
  parameter logic [23:0] TIMEOUT_CYC = 24'd12_000_000,
  parameter logic [31:0] LO_TH       = 32'd1000,
  parameter logic [31:0] HI_TH       = 32'd1_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        cont_i,
  input  logic [2:0]  range_cfg_i,
  input  logic        meas_done_i,
  input  logic [63:0] meas_data_i,
  output logic        gate_st_o,
  output logic [7:0]  gate_time_o,
  output logic        busy_o,
  output logic        res_vld_o,
  output logic [2:0]  res_range_o,
  output logic        timeout_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT,
    ST_EVAL,
    ST_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic        cont_q, cont_d;
  logic [2:0]  range_q, range_d;
  logic [23:0] to_cnt_q, to_cnt_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic        gate_st_q, gate_st_d;
  logic [7:0]  gate_time_q, gate_time_d;
  logic        busy_q, busy_d;
  logic        res_vld_q, res_vld_d;
  logic [2:0]  res_range_q, res_range_d;
  logic        timeout_q, timeout_d;

`ifdef GATE_SCHED_AUTO_RANGE_EN
  // Only the signal count drives range decisions; the reference count
  // belongs to the downstream frequency computation.
  logic [31:0] sig_q, sig_d;
  logic        unused_ref;
  assign unused_ref = ^meas_data_i[63:32];
`else
  logic        unused_cfg;
  assign unused_cfg = ^{meas_data_i, LO_TH, HI_TH};
`endif

  assign gate_st_o   = gate_st_q;
  assign gate_time_o = gate_time_q;
  assign busy_o      = busy_q;
  assign res_vld_o   = res_vld_q;
  assign res_range_o = res_range_q;
  assign timeout_o   = timeout_q;

  // Next-state and next-output computation for the gate sequencer.
  always_comb begin
    state_d     = state_q;
    cont_d      = cont_q;
    range_d     = range_q;
    to_cnt_d    = to_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    gate_st_d   = 1'b0;
    res_vld_d   = 1'b0;
    res_range_d = res_range_q;
    timeout_d   = timeout_q;
`ifdef GATE_SCHED_AUTO_RANGE_EN
    sig_d       = sig_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start_i && !stop_i) begin
          cont_d    = cont_i;
          range_d   = range_cfg_i;
          timeout_d = 1'b0;
          state_d   = ST_ARM;
        end
      end
      ST_ARM: begin
        gate_st_d = 1'b1;
        to_cnt_d  = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        // Result pulse is raised on entry to EVAL so it lands one cycle
        // after meas_done_i; the range update follows on EVAL exit.
        if (meas_done_i) begin
`ifdef GATE_SCHED_AUTO_RANGE_EN
          sig_d       = meas_data_i[31:0];
`endif
          res_vld_d   = 1'b1;
          res_range_d = range_q;
          state_d     = ST_EVAL;
        end else if (to_cnt_q == TIMEOUT_CYC - 24'd1) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 24'd1;
        end
      end
      ST_EVAL: begin
`ifdef GATE_SCHED_AUTO_RANGE_EN
        if (sig_q < LO_TH && range_q != 3'd7) begin
          range_d = range_q + 3'd1;
        end else if (sig_q > HI_TH && range_q != 3'd0) begin
          range_d = range_q - 3'd1;
        end
`endif
        hold_cnt_d = '0;
        state_d    = cont_q ? ST_HOLD : ST_IDLE;
      end
      ST_HOLD: begin
        if (HOLDOFF_CYC == 0 || hold_cnt_q == HOLDOFF_CYC - 1) begin
          state_d = ST_ARM;
        end else begin
          hold_cnt_d = hold_cnt_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Host stop overrides everything except the range already in use.
    if (stop_i && state_q != ST_IDLE) begin
      state_d     = ST_IDLE;
      gate_st_d   = 1'b0;
      res_vld_d   = 1'b0;
      res_range_d = res_range_q;
      timeout_d   = timeout_q;
      range_d     = range_q;
    end

    gate_time_d = 8'h01 << range_d;
    busy_d      = (state_d != ST_IDLE);
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cont_q      <= 1'b0;
      range_q     <= '0;
      to_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      gate_st_q   <= 1'b0;
      gate_time_q <= 8'h01;
      busy_q      <= 1'b0;
      res_vld_q   <= 1'b0;
      res_range_q <= '0;
      timeout_q   <= 1'b0;
`ifdef GATE_SCHED_AUTO_RANGE_EN
      sig_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cont_q      <= cont_d;
      range_q     <= range_d;
      to_cnt_q    <= to_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      gate_st_q   <= gate_st_d;
      gate_time_q <= gate_time_d;
      busy_q      <= busy_d;
      res_vld_q   <= res_vld_d;
      res_range_q <= res_range_d;
      timeout_q   <= timeout_d;
`ifdef GATE_SCHED_AUTO_RANGE_EN
      sig_q       <= sig_d;
`endif
    end
  end

endmodule

// File: tb/tb_gate_sched.sv
// tb_gate_sched: scoreboard bench for gate_sched. The driver derives the
// expected gate/result pulses (value and cycle) from the session rules and
// queues them; a negedge monitor pops and compares every pulse it sees.
module tb_gate_sched;

  localparam int unsigned H      = 16;
  localparam logic [31:0] LO_TH  = 32'd1000;
  localparam logic [31:0] HI_TH  = 32'd1_000_000;
`ifdef GATE_SCHED_AUTO_RANGE_EN
  localparam bit          AUTO   = 1'b1;
`else
  localparam bit          AUTO   = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        stop_i;
  logic        cont_i;
  logic [2:0]  range_cfg_i;
  logic        meas_done_i;
  logic [63:0] meas_data_i;
  logic        gate_st_o;
  logic [7:0]  gate_time_o;
  logic        busy_o;
  logic        res_vld_o;
  logic [2:0]  res_range_o;
  logic        timeout_o;

  gate_sched #(
    .HOLDOFF_CYC (H),
    .TIMEOUT_CYC (24'd100)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .cont_i      (cont_i),
    .range_cfg_i (range_cfg_i),
    .meas_done_i (meas_done_i),
    .meas_data_i (meas_data_i),
    .gate_st_o   (gate_st_o),
    .gate_time_o (gate_time_o),
    .busy_o      (busy_o),
    .res_vld_o   (res_vld_o),
    .res_range_o (res_range_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    bit          is_res;
    logic [7:0]  val;
    int unsigned at;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] dir_counts[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h (cyc %0d)", name, got, exp, cyc);
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic wait_until(input int unsigned t);
    while (cyc < t) step();
    check("sched_align", cyc, t);
  endtask

  task automatic push_exp(input bit is_res, input logic [7:0] val, input int unsigned at);
    exp_t e;
    e.is_res = is_res;
    e.val    = val;
    e.at     = at;
    sbq.push_back(e);
  endtask

  // Reference range rule: step toward the band, saturating at 0 and 7.
  function automatic logic [2:0] next_range(input logic [2:0] r, input logic [31:0] c);
    if (AUTO && c < LO_TH && r != 3'd7) return r + 3'd1;
    if (AUTO && c > HI_TH && r != 3'd0) return r - 3'd1;
    return r;
  endfunction

  function automatic logic [31:0] next_count();
    if (dir_counts.size() != 0) return dir_counts.pop_front();
    case ($urandom_range(0, 5))
      0:       return 32'($urandom_range(0, 999));
      1:       return LO_TH;
      2:       return 32'($urandom_range(1001, 999_999));
      3:       return HI_TH;
      4:       return HI_TH + 32'd1 + 32'($urandom_range(0, 1000));
      default: return 32'($urandom);
    endcase
  endfunction

  // Monitor: every gate/result pulse must match the head of the scoreboard.
  task automatic mon_pulse(input bit is_res, input logic [7:0] val);
    exp_t e;
    if (sbq.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_%s got=0x%0h exp=no pulse (cyc %0d)", is_res ? "res" : "gate", val, cyc);
    end else begin
      e = sbq.pop_front();
      check(is_res ? "res_kind" : "gate_kind", is_res, e.is_res);
      check(is_res ? "res_range" : "gate_time", val, e.val);
      check(is_res ? "res_cycle" : "gate_cycle", cyc, e.at);
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (gate_st_o) mon_pulse(1'b0, gate_time_o);
      if (res_vld_o) mon_pulse(1'b1, {5'd0, res_range_o});
    end
  end

  task automatic done_pulse(input logic [31:0] cnt);
    meas_done_i = 1'b1;
    meas_data_i = {32'($urandom), cnt};
    step();
    meas_done_i = 1'b0;
    meas_data_i = {32'($urandom), 32'($urandom)};
  endtask

  task automatic stop_pulse();
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
  endtask

  task automatic idle_checks(input string tag, input logic [2:0] r);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_gate_time"}, gate_time_o, 8'h01 << r);
    check({tag, "_sb_empty"}, sbq.size(), 0);
  endtask

  // One host session: start, ngates gates, then natural end or a stop.
  task automatic run_session(input bit cont, input logic [2:0] rcfg,
                             input int unsigned ngates, input bit stop_in_wait);
    int unsigned g, d, s, x;
    logic [2:0]  r;
    logic [31:0] cnt;
    bit          last;
    r = rcfg;
    g = cyc + 2;
    push_exp(1'b0, 8'h01 << r, g);
    start_i     = 1'b1;
    cont_i      = cont;
    range_cfg_i = rcfg;
    step();
    start_i     = 1'b0;
    cont_i      = 1'($urandom);
    range_cfg_i = 3'($urandom);
    check("start_clears_timeout", timeout_o, 0);
    for (int unsigned k = 0; k < ngates; k++) begin
      last = (k == ngates - 1);
      if (k != 0) push_exp(1'b0, 8'h01 << r, g);
      d = $urandom_range(1, 60);
      if (last && stop_in_wait) begin
        s = $urandom_range(0, d - 1);
        wait_until(g + s);
        stop_pulse();
        wait_until(g + d);
        done_pulse(next_count());
      end else begin
        if (d >= 3) begin
          wait_until(g + 1);
          start_i     = 1'b1;
          cont_i      = 1'($urandom);
          range_cfg_i = 3'($urandom);
          step();
          start_i     = 1'b0;
        end
        cnt = next_count();
        push_exp(1'b1, {5'd0, r}, g + d + 1);
        wait_until(g + d);
        done_pulse(cnt);
        r = next_range(r, cnt);
        if (!last) begin
          g = g + d + 3 + H;
        end else if (cont) begin
          x = g + d + 2 + $urandom_range(0, H - 1);
          wait_until(x);
          stop_pulse();
        end
      end
    end
    repeat (3) step();
    idle_checks("session_end", r);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=no finish exp=finish (cyc %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int unsigned g;
    rst_i       = 1'b1;
    start_i     = 1'b0;
    stop_i      = 1'b0;
    cont_i      = 1'b0;
    range_cfg_i = 3'd0;
    meas_done_i = 1'b0;
    meas_data_i = '0;
    repeat (3) step();
    check("rst_gate_time", gate_time_o, 8'h01);
    check("rst_gate_st", gate_st_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_res_vld", res_vld_o, 0);
    check("rst_res_range", res_range_o, 0);
    check("rst_timeout", timeout_o, 0);
    rst_i = 1'b0;
    step();

    // Single shot, range 3, count 5000.
    dir_counts.push_back(32'd5000);
    run_session(1'b0, 3'd3, 1, 1'b0);

    // Continuous auto-range walk from range 2 with low counts.
    dir_counts = '{32'd500, 32'd500, 32'd500};
    run_session(1'b1, 3'd2, 3, 1'b0);

    // Saturation and threshold-equality edges.
    dir_counts.push_back(32'd10);
    run_session(1'b0, 3'd7, 1, 1'b0);
    dir_counts.push_back(32'd2_000_000);
    run_session(1'b0, 3'd0, 1, 1'b0);
    dir_counts.push_back(32'd1000);
    run_session(1'b0, 3'd4, 1, 1'b0);
    dir_counts.push_back(32'd1_000_000);
    run_session(1'b0, 3'd4, 1, 1'b0);

    // Continuous at range 5 with tiny counts.
    dir_counts = '{32'd10, 32'd10, 32'd10};
    run_session(1'b1, 3'd5, 3, 1'b0);

    // Timeout: no done within 100 cycles of the gate pulse.
    g = cyc + 2;
    push_exp(1'b0, 8'h40, g);
    start_i = 1'b1; cont_i = 1'b0; range_cfg_i = 3'd6;
    step();
    start_i = 1'b0;
    wait_until(g + 99);
    check("timeout_early", timeout_o, 0);
    check("timeout_busy_wait", busy_o, 1);
    step();
    check("timeout_set", timeout_o, 1);
    check("timeout_idle", busy_o, 0);
    wait_until(g + 105);
    done_pulse(32'd10);
    repeat (3) step();
    check("timeout_sticky", timeout_o, 1);
    idle_checks("timeout_end", 3'd6);

    // Start and stop together in IDLE: stop wins.
    start_i = 1'b1; stop_i = 1'b1; cont_i = 1'b1; range_cfg_i = 3'd2;
    step();
    start_i = 1'b0; stop_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("collision_busy", busy_o, 0);
      step();
    end
    idle_checks("collision_end", 3'd6);

    // Stop during WAIT, late done ignored.
    run_session(1'b1, 3'd5, 2, 1'b1);

    // Reset mid-measurement aborts with no result.
    g = cyc + 2;
    push_exp(1'b0, 8'h20, g);
    start_i = 1'b1; cont_i = 1'b1; range_cfg_i = 3'd5;
    step();
    start_i = 1'b0;
    wait_until(g + 5);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    wait_until(g + 10);
    done_pulse(32'd10);
    repeat (3) step();
    check("rst_mid_res_range", res_range_o, 0);
    idle_checks("rst_mid_end", 3'd0);

    // Randomized sessions.
    for (int n = 0; n < 30; n++) begin
      bit          c;
      int unsigned ng;
      c  = 1'($urandom);
      ng = c ? $urandom_range(1, 4) : 1;
      run_session(c, 3'($urandom), ng, $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 3)) step();
    end

    check("final_sb_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
